// File: rtl/context_switch_controller.sv
// Round-robin context switcher: saves the interrupted PC, picks the next READY process and pulses pc_load 3 cycles after a request edge.
// Request edges arriving while busy are dropped; io_done and proc_create are accepted in every state.
module context_switch_controller #(
    parameter int          PID_W = 2,
    parameter logic [31:0] OS_PC = 32'd0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             troca_contexto,
    input  logic             intrucaoIOContexto,
    input  logic             fimProcesso,
    input  logic [31:0]      pc_processo_trocado,
    input  logic             io_done,
    input  logic [PID_W-1:0] io_pid,
    input  logic             proc_create,
    input  logic [31:0]      proc_create_pc,
    output logic             pc_load,
    output logic [31:0]      pc_next,
    output logic [PID_W-1:0] processo_atual,
    output logic             proc_valid,
    output logic             busy,
    output logic             proc_create_err
);

    localparam int NUM_PROC = 1 << PID_W;

    typedef enum logic [1:0] {SL_FREE, SL_READY, SL_BLOCKED, SL_RUNNING} slot_t;
    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_SELECT, ST_LOAD} fsm_t;

    fsm_t             r_state;
    fsm_t             w_state_next;
    slot_t            r_slot_st [NUM_PROC];
    logic [31:0]      r_slot_pc [NUM_PROC];
    logic             r_prev_troca;
    logic             r_prev_io;
    logic             r_prev_fim;
    logic             r_kind_fim;
    logic             r_kind_io;
    logic [PID_W-1:0] r_search_base;
    logic [PID_W-1:0] r_cur;
    logic             r_proc_valid;
    logic [31:0]      r_pc_next;
    logic             r_create_err;

    logic             w_troca_edge;
    logic             w_io_edge;
    logic             w_fim_edge;
    logic             w_req;
    logic             w_any_ready;
    logic             w_os_dispatch;
    logic             w_free_found;
    logic [PID_W-1:0] w_free_idx;
    logic             w_win_found;
    logic [PID_W-1:0] w_win_idx;

    assign w_troca_edge  = troca_contexto & ~r_prev_troca;
    assign w_io_edge     = intrucaoIOContexto & ~r_prev_io;
    assign w_fim_edge    = fimProcesso & ~r_prev_fim;
    assign w_req         = (r_state == ST_IDLE) && r_proc_valid && (w_troca_edge || w_io_edge || w_fim_edge);
    assign w_os_dispatch = (r_state == ST_IDLE) && !r_proc_valid && w_any_ready;

    always_comb begin
        w_any_ready  = 1'b0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        for (int i = 0; i < NUM_PROC; i++) begin
            if (r_slot_st[i] == SL_READY)
                w_any_ready = 1'b1;
            if (!w_free_found && r_slot_st[i] == SL_FREE) begin
                w_free_found = 1'b1;
                w_free_idx   = PID_W'(i);
            end
        end
    end

    // Walk from the search base so the interrupted process is examined last.
    always_comb begin
        logic [PID_W-1:0] idx;
        w_win_found = 1'b0;
        w_win_idx   = '0;
        idx         = '0;
        for (int k = 0; k < NUM_PROC; k++) begin
            idx = r_search_base + PID_W'(k);
            if (!w_win_found && r_slot_st[idx] == SL_READY) begin
                w_win_found = 1'b1;
                w_win_idx   = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_req)
                    w_state_next = ST_SAVE;
                else if (w_os_dispatch)
                    w_state_next = ST_SELECT;
            end
            ST_SAVE:   w_state_next = ST_SELECT;
            ST_SELECT: w_state_next = ST_LOAD;
            ST_LOAD:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_load = (r_state == ST_LOAD);
        busy    = (r_state != ST_IDLE);
    end

    assign pc_next         = r_pc_next;
    assign processo_atual  = r_cur;
    assign proc_valid      = r_proc_valid;
    assign proc_create_err = r_create_err;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_prev_troca  <= 1'b0;
            r_prev_io     <= 1'b0;
            r_prev_fim    <= 1'b0;
            r_kind_fim    <= 1'b0;
            r_kind_io     <= 1'b0;
            r_search_base <= '0;
            r_cur         <= '0;
            r_proc_valid  <= 1'b0;
            r_pc_next     <= '0;
            r_create_err  <= 1'b0;
            for (int i = 0; i < NUM_PROC; i++) begin
                r_slot_st[i] <= SL_FREE;
                r_slot_pc[i] <= '0;
            end
        end else begin
            r_prev_troca <= troca_contexto;
            r_prev_io    <= intrucaoIOContexto;
            r_prev_fim   <= fimProcesso;
            r_create_err <= proc_create && !w_free_found;

            if (w_req) begin
                r_kind_fim    <= w_fim_edge;
                r_kind_io     <= !w_fim_edge && w_io_edge;
                r_search_base <= r_cur + PID_W'(1);
            end else if (w_os_dispatch) begin
                r_search_base <= '0;
            end

            if (r_state == ST_SELECT) begin
                r_pc_next    <= w_win_found ? r_slot_pc[w_win_idx] : OS_PC;
                r_proc_valid <= w_win_found;
                if (w_win_found)
                    r_cur <= w_win_idx;
            end

            // The four writers target disjoint slot states, so the order only matters for readability.
            for (int i = 0; i < NUM_PROC; i++) begin
                if (r_state == ST_SAVE && r_cur == PID_W'(i)) begin
                    if (r_kind_fim) begin
                        r_slot_st[i] <= SL_FREE;
                    end else begin
                        r_slot_st[i] <= r_kind_io ? SL_BLOCKED : SL_READY;
                        r_slot_pc[i] <= pc_processo_trocado;
                    end
                end else if (r_state == ST_SELECT && w_win_found && w_win_idx == PID_W'(i)) begin
                    r_slot_st[i] <= SL_RUNNING;
                end else if (io_done && io_pid == PID_W'(i) && r_slot_st[i] == SL_BLOCKED) begin
                    r_slot_st[i] <= SL_READY;
                end else if (proc_create && w_free_found && w_free_idx == PID_W'(i)) begin
                    r_slot_st[i] <= SL_READY;
                    r_slot_pc[i] <= proc_create_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_context_switch_controller.sv
// Self-checking bench for context_switch_controller: directed scenarios plus randomized ops vs. a slot-table model.
module tb_context_switch_controller;

    logic        clock;
    logic        reset;
    logic        troca_contexto;
    logic        intrucaoIOContexto;
    logic        fimProcesso;
    logic [31:0] pc_processo_trocado;
    logic        io_done;
    logic [1:0]  io_pid;
    logic        proc_create;
    logic [31:0] proc_create_pc;
    logic        pc_load;
    logic [31:0] pc_next;
    logic [1:0]  processo_atual;
    logic        proc_valid;
    logic        busy;
    logic        proc_create_err;

    int checks = 0;
    int passed = 0;

    localparam int M_FREE = 0, M_READY = 1, M_BLOCKED = 2, M_RUNNING = 3;
    int          m_st [4];
    logic [31:0] m_pc [4];
    int          m_cur;
    bit          m_valid;

    context_switch_controller #(.PID_W(2), .OS_PC(32'd0)) dut (
        .clock               (clock),
        .reset               (reset),
        .troca_contexto      (troca_contexto),
        .intrucaoIOContexto  (intrucaoIOContexto),
        .fimProcesso         (fimProcesso),
        .pc_processo_trocado (pc_processo_trocado),
        .io_done             (io_done),
        .io_pid              (io_pid),
        .proc_create         (proc_create),
        .proc_create_pc      (proc_create_pc),
        .pc_load             (pc_load),
        .pc_next             (pc_next),
        .processo_atual      (processo_atual),
        .proc_valid          (proc_valid),
        .busy                (busy),
        .proc_create_err     (proc_create_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        troca_contexto = 0; intrucaoIOContexto = 0; fimProcesso = 0;
        io_done = 0; io_pid = 0; proc_create = 0;
        pc_processo_trocado = 0; proc_create_pc = 0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            m_st[i] = M_FREE;
            m_pc[i] = 0;
        end
        m_cur = 0;
        m_valid = 0;
    endtask

    // Applies one set of pulses for one cycle, then watches six cycles for pc_load.
    task automatic run_op(input logic c, input logic [31:0] cpc, input logic tr, input logic io,
                          input logic fim, input logic [31:0] spc, input logic iod, input logic [1:0] iop,
                          output int nl, output int lat, output logic [31:0] lpc, output logic [1:0] lpid,
                          output logic lv, output logic err);
        proc_create = c; proc_create_pc = cpc;
        troca_contexto = tr; intrucaoIOContexto = io; fimProcesso = fim;
        pc_processo_trocado = spc; io_done = iod; io_pid = iop;
        nl = 0; lat = 0; lpc = 0; lpid = 0; lv = 0; err = 0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            if (t == 1) begin
                err = proc_create_err;
                proc_create = 0; troca_contexto = 0; intrucaoIOContexto = 0;
                fimProcesso = 0; io_done = 0;
            end
            if (pc_load === 1'b1) begin
                nl++; lat = t; lpc = pc_next; lpid = processo_atual; lv = proc_valid;
            end
        end
    endtask

    function automatic int m_pick(int start);
        for (int k = 0; k < 4; k++) begin
            if (m_st[(start + k) % 4] == M_READY)
                return (start + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({pc_load, pc_next, processo_atual, proc_valid, busy, proc_create_err} !== 37'd0)
            $display("FAIL reset_outputs: got load=%0b pc=%0d pid=%0d v=%0b busy=%0b err=%0b, want all 0",
                     pc_load, pc_next, processo_atual, proc_valid, busy, proc_create_err);
        else passed++;
        do_reset();
    endtask

    task automatic test_create_dispatch();
        int nl, lat; logic [31:0] lpc; logic [1:0] lpid; logic lv, err;
        do_reset();
        run_op(1, 400, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lat !== 3) $display("FAIL create_load_timing: loads=%0d at=%0d, want 1 at 3", nl, lat);
        else passed++;
        checks++;
        if (lpc !== 32'd400 || lpid !== 2'd0 || lv !== 1'b1)
            $display("FAIL create_load_value: pc=%0d pid=%0d v=%0b, want 400 0 1", lpc, lpid, lv);
        else passed++;
    endtask

    task automatic test_quantum_switch();
        int nl, lat; logic [31:0] lpc; logic [1:0] lpid; logic lv, err;
        do_reset();
        run_op(1, 400, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(1, 500, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 0) $display("FAIL create_while_running: loads=%0d, want 0", nl);
        else passed++;
        run_op(0, 0, 1, 0, 0, 421, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lat !== 3 || lpc !== 32'd500 || lpid !== 2'd1 || lv !== 1'b1)
            $display("FAIL quantum_to_p1: loads=%0d at=%0d pc=%0d pid=%0d v=%0b, want 1 3 500 1 1", nl, lat, lpc, lpid, lv);
        else passed++;
        run_op(0, 0, 1, 0, 0, 510, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lpc !== 32'd421 || lpid !== 2'd0)
            $display("FAIL quantum_back_p0: loads=%0d pc=%0d pid=%0d, want 1 421 0", nl, lpc, lpid);
        else passed++;
    endtask

    task automatic test_io_block();
        int nl, lat; logic [31:0] lpc; logic [1:0] lpid; logic lv, err;
        do_reset();
        run_op(1, 400, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(0, 0, 0, 1, 0, 430, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lat !== 3 || lpc !== 32'd0 || lv !== 1'b0 || lpid !== 2'd0)
            $display("FAIL io_to_os: loads=%0d at=%0d pc=%0d v=%0b pid=%0d, want 1 3 0 0 0", nl, lat, lpc, lv, lpid);
        else passed++;
        run_op(0, 0, 0, 0, 0, 0, 1, 2, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 0) $display("FAIL io_done_not_blocked: loads=%0d, want 0", nl);
        else passed++;
        run_op(0, 0, 0, 0, 0, 0, 1, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lat !== 3 || lpc !== 32'd430 || lv !== 1'b1 || lpid !== 2'd0)
            $display("FAIL io_done_resume: loads=%0d at=%0d pc=%0d v=%0b pid=%0d, want 1 3 430 1 0", nl, lat, lpc, lv, lpid);
        else passed++;
    endtask

    task automatic test_fim_priority();
        int nl, lat; logic [31:0] lpc; logic [1:0] lpid; logic lv, err;
        do_reset();
        run_op(1, 100, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(1, 200, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(0, 0, 1, 0, 0, 111, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(0, 0, 1, 0, 1, 999, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lpc !== 32'd111 || lpid !== 2'd0)
            $display("FAIL fim_over_troca: loads=%0d pc=%0d pid=%0d, want 1 111 0", nl, lpc, lpid);
        else passed++;
        run_op(1, 777, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(0, 0, 1, 0, 0, 5, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lpc !== 32'd777 || lpid !== 2'd1)
            $display("FAIL freed_slot_reused: loads=%0d pc=%0d pid=%0d, want 1 777 1", nl, lpc, lpid);
        else passed++;
    endtask

    task automatic test_table_full_and_hold();
        int nl, lat, loads; logic [31:0] lpc; logic [1:0] lpid; logic lv, err;
        do_reset();
        for (int i = 1; i <= 4; i++)
            run_op(1, 32'(i * 10), 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(1, 50, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (err !== 1'b1 || nl !== 0) $display("FAIL create_err_pulse: err=%0b loads=%0d, want 1 0", err, nl);
        else passed++;
        checks++;
        if (proc_create_err !== 1'b0) $display("FAIL create_err_width: err=%0b later, want 0", proc_create_err);
        else passed++;
        loads = 0;
        pc_processo_trocado = 11;
        troca_contexto = 1;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (pc_load === 1'b1) begin
                loads++;
                lpc = pc_next;
                lpid = processo_atual;
            end
        end
        troca_contexto = 0;
        tick();
        checks++;
        if (loads !== 1 || lpc !== 32'd20 || lpid !== 2'd1)
            $display("FAIL troca_held: loads=%0d pc=%0d pid=%0d, want 1 20 1", loads, lpc, lpid);
        else passed++;
        run_op(0, 0, 1, 0, 0, 21, 0, 0, nl, lat, lpc, lpid, lv, err);
        checks++;
        if (nl !== 1 || lpc !== 32'd30 || lpid !== 2'd2)
            $display("FAIL table_unchanged: loads=%0d pc=%0d pid=%0d, want 1 30 2", nl, lpc, lpid);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int nl, lat, loads; logic [31:0] lpc; logic [1:0] lpid; logic lv, err;
        do_reset();
        run_op(1, 10, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        run_op(1, 20, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
        pc_processo_trocado = 15;
        troca_contexto = 1;
        tick();
        troca_contexto = 0;
        tick();
        checks++;
        if (busy !== 1'b1 || pc_load !== 1'b0) $display("FAIL mid_select_busy: busy=%0b load=%0b, want 1 0", busy, pc_load);
        else passed++;
        reset = 0;
        tick();
        checks++;
        if ({pc_load, pc_next, processo_atual, proc_valid, busy, proc_create_err} !== 37'd0)
            $display("FAIL reset_mid_outputs: load=%0b pc=%0d pid=%0d v=%0b busy=%0b err=%0b, want all 0",
                     pc_load, pc_next, processo_atual, proc_valid, busy, proc_create_err);
        else passed++;
        reset = 1;
        loads = 0;
        for (int t = 0; t < 6; t++) begin
            tick();
            if (pc_load === 1'b1) loads++;
        end
        checks++;
        if (loads !== 0) $display("FAIL reset_mid_noload: loads=%0d, want 0", loads);
        else passed++;
    endtask

    task automatic test_random_ops();
        int nl, lat, op, f, w, exp_nl, exp_pid;
        logic [31:0] lpc, rpc, exp_pc; logic [1:0] lpid, pid; logic lv, err, exp_v, exp_err;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 5));
            rpc = $urandom;
            pid = 2'($urandom_range(0, 3));
            exp_nl = 0; exp_err = 0; exp_pc = 0; exp_pid = m_cur; exp_v = m_valid;
            if (op <= 1) begin
                f = -1;
                for (int i = 3; i >= 0; i--) if (m_st[i] == M_FREE) f = i;
                if (f < 0) exp_err = 1;
                else begin m_st[f] = M_READY; m_pc[f] = rpc; end
                run_op(1, rpc, 0, 0, 0, 0, 0, 0, nl, lat, lpc, lpid, lv, err);
            end else if (op == 5) begin
                if (m_st[pid] == M_BLOCKED) m_st[pid] = M_READY;
                run_op(0, 0, 0, 0, 0, 0, 1, pid, nl, lat, lpc, lpid, lv, err);
            end else begin
                if (m_valid) begin
                    if (op == 4) m_st[m_cur] = M_FREE;
                    else begin
                        m_st[m_cur] = (op == 3) ? M_BLOCKED : M_READY;
                        m_pc[m_cur] = rpc;
                    end
                    w = m_pick((m_cur + 1) % 4);
                    exp_nl = 1;
                    if (w >= 0) begin m_st[w] = M_RUNNING; m_cur = w; exp_pc = m_pc[w]; end
                    m_valid = (w >= 0);
                    exp_pid = m_cur; exp_v = m_valid;
                end
                run_op(0, 0, op == 2, op == 3, op == 4, rpc, 0, 0, nl, lat, lpc, lpid, lv, err);
            end
            if (op <= 1 || op == 5) begin
                w = m_pick(0);
                if (!m_valid && w >= 0) begin
                    exp_nl = 1; m_st[w] = M_RUNNING; m_cur = w; m_valid = 1;
                    exp_pc = m_pc[w]; exp_pid = w; exp_v = 1;
                end
            end
            checks++;
            if (nl !== exp_nl || err !== exp_err)
                $display("FAIL rand_loads it=%0d op=%0d: loads=%0d err=%0b, want %0d %0b", it, op, nl, err, exp_nl, exp_err);
            else passed++;
            if (exp_nl == 1) begin
                checks++;
                if (lat !== 3 || lpc !== exp_pc || lpid !== 2'(exp_pid) || lv !== exp_v)
                    $display("FAIL rand_load it=%0d op=%0d: at=%0d pc=%0h pid=%0d v=%0b, want 3 %0h %0d %0b",
                             it, op, lat, lpc, lpid, lv, exp_pc, exp_pid, exp_v);
                else passed++;
            end
            checks++;
            if (proc_valid !== m_valid || (m_valid && processo_atual !== 2'(m_cur)) || busy !== 1'b0)
                $display("FAIL rand_state it=%0d: v=%0b pid=%0d busy=%0b, want %0b %0d 0", it, proc_valid, processo_atual, busy, m_valid, m_cur);
            else passed++;
        end
    endtask

    initial begin
        reset = 0;
        troca_contexto = 0; intrucaoIOContexto = 0; fimProcesso = 0;
        io_done = 0; io_pid = 0; proc_create = 0;
        pc_processo_trocado = 0; proc_create_pc = 0;
        test_reset();
        test_create_dispatch();
        test_quantum_switch();
        test_io_block();
        test_fim_priority();
        test_table_full_and_hold();
        test_reset_mid();
        test_random_ops();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
